demux_memoria: RTL

Registered 1-to-2 demultiplexer with per-lane buffering, the receive-side counterpart of the team's 2:1 registered mux. It accepts a WIDTH-bit word stream on one input port and steers each accepted word into one of two lane FIFOs. The lane is chosen by `selector`, or by an internal alternating pointer when auto-select is compiled in. Each lane presents its oldest word registered, with a valid/pop handshake toward downstream logic.

---
 rtl/demux_memoria.sv | 115 +++++++++++
 1 files changed

// File: rtl/demux_memoria.sv
// Registered 1-to-2 demultiplexer: steers an input word stream into two lane FIFOs.
// Optional DEMUX_AUTOSEL_EN replaces `selector` with an internal alternating lane pointer.
module demux_memoria #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             selector,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out0,
    output logic             valid_out0,
    input  logic             pop0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out1,
    input  logic             pop1,
    output logic             err
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q  [2][DEPTH];
    logic [WIDTH-1:0] mem_d  [2][DEPTH];
    logic [AW-1:0]    wptr_q [2];
    logic [AW-1:0]    wptr_d [2];
    logic [AW-1:0]    rptr_q [2];
    logic [AW-1:0]    rptr_d [2];
    logic [CW-1:0]    cnt_q  [2];
    logic [CW-1:0]    cnt_d  [2];
    logic             err_q, err_d;

    logic       tgt;
    logic       push;
    logic [1:0] lane_valid;
    logic [1:0] lane_full;
    logic [1:0] pop_req;
    logic [1:0] pop_ok;

`ifdef DEMUX_AUTOSEL_EN
    logic sel_q, sel_d;

    assign tgt = sel_q;

    // Pointer only advances on an accepted word, so a stalled full lane keeps its turn.
    always_comb begin
        sel_d = sel_q ^ push;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
        end
    end
`else
    assign tgt = selector;
`endif

    assign lane_valid = {cnt_q[1] != '0, cnt_q[0] != '0};
    assign lane_full  = {cnt_q[1] == CW'(DEPTH), cnt_q[0] == CW'(DEPTH)};
    assign pop_req    = {pop1, pop0};
    assign pop_ok     = pop_req & lane_valid;

    // Readiness looks only at registered occupancy, never at this cycle's pops.
    assign ready_in = !lane_full[tgt];
    assign push     = valid_in && ready_in;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        err_d  = err_q | (|(pop_req & ~lane_valid));
        for (int i = 0; i < 2; i++) begin
            if (push && (tgt == 1'(i))) begin
                mem_d[i][wptr_q[i]] = data_in;
                wptr_d[i]           = wptr_q[i] + AW'(1);
            end
            if (pop_ok[i]) begin
                rptr_d[i] = rptr_q[i] + AW'(1);
            end
            cnt_d[i] = cnt_q[i] + CW'(push && (tgt == 1'(i))) - CW'(pop_ok[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign data_out0  = mem_q[0][rptr_q[0]];
    assign data_out1  = mem_q[1][rptr_q[1]];
    assign valid_out0 = lane_valid[0];
    assign valid_out1 = lane_valid[1];
    assign err        = err_q;

endmodule
